// File: rtl/dmem_hold_arbiter_if.sv
// Bus bundle between the data-memory hold arbiter, its requesting channels, the CPU and data memory.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface dmem_hold_arbiter_if #(
    parameter int N_CH = 4,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [N_CH-1:0]    ch_hold;
    logic [N_CH-1:0]    ch_hold_ack;
    logic [N_CH*AW-1:0] ch_addr;
    logic [N_CH*DW-1:0] ch_wdata;
    logic [N_CH-1:0]    ch_we;
    logic [AW-1:0]      cpu_addr;
    logic [DW-1:0]      cpu_wdata;
    logic               cpu_we;
    logic               hold_req;
    logic               cpu_hold_ack;
    logic [AW-1:0]      dmem_addr;
    logic [DW-1:0]      dmem_wdata;
    logic               dmem_we;
    logic [CW-1:0]      grant_id;
    logic               busy;

    modport slave (
        input  ch_hold, ch_addr, ch_wdata, ch_we,
        input  cpu_addr, cpu_wdata, cpu_we, cpu_hold_ack,
        output ch_hold_ack, hold_req, dmem_addr, dmem_wdata, dmem_we, grant_id, busy
    );

    modport master (
        output ch_hold, ch_addr, ch_wdata, ch_we,
        output cpu_addr, cpu_wdata, cpu_we, cpu_hold_ack,
        input  ch_hold_ack, hold_req, dmem_addr, dmem_wdata, dmem_we, grant_id, busy
    );
endinterface

// File: rtl/dmem_hold_arbiter.sv
// Round-robin arbiter handing the data-memory port from the CPU to N_CH bus-master channels via HOLD/ACK.
// Optional burst preemption enabled by defining DMEM_ARB_PREEMPT_EN.
module dmem_hold_arbiter #(
    parameter int N_CH      = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    dmem_hold_arbiter_if.slave   bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    if (N_CH < 1 || N_CH > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_param
        $error("dmem_hold_arbiter: N_CH or MAX_BURST out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_RELEASE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] grant_id_q, grant_id_d;
    logic [CW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] win_id;
    logic [CW-1:0] idx;
    logic          win_found;
    logic          any_hold;
    logic          enter_grant;
    logic          burst_limit;

    logic [AW-1:0] ch_addr_arr  [N_CH];
    logic [DW-1:0] ch_wdata_arr [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_unpack
        assign ch_addr_arr[i]  = bus.ch_addr[i*AW +: AW];
        assign ch_wdata_arr[i] = bus.ch_wdata[i*DW +: DW];
    end

    function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] g);
        if (int'(g) == N_CH - 1) return '0;
        return g + 1'b1;
    endfunction

    assign any_hold = |bus.ch_hold;

    // First requesting channel at or above rr_ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = CW'((int'(rr_ptr_q) + k) % N_CH);
            if (!win_found && bus.ch_hold[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        rr_ptr_d    = rr_ptr_q;
        enter_grant = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any_hold) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!any_hold) begin
                    state_d = ST_IDLE;
                end else if (bus.cpu_hold_ack) begin
                    state_d     = ST_GRANT;
                    grant_id_d  = win_id;
                    rr_ptr_d    = next_ch(win_id);
                    enter_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!bus.cpu_hold_ack) begin
                    // Rewind so the interrupted channel wins again once the CPU re-acknowledges.
                    state_d  = ST_REQ;
                    rr_ptr_d = grant_id_q;
                end else if (!bus.ch_hold[grant_id_q] || burst_limit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (any_hold) begin
                    state_d     = ST_GRANT;
                    grant_id_d  = win_id;
                    rr_ptr_d    = next_ch(win_id);
                    enter_grant = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

`ifdef DMEM_ARB_PREEMPT_EN
    logic [7:0]      burst_q, burst_d;
    logic [N_CH-1:0] others_hold;

    assign others_hold = bus.ch_hold & ~(N_CH'(1) << grant_id_q);
    assign burst_limit = (burst_q >= 8'(MAX_BURST - 1)) && (|others_hold);

    always_comb begin
        burst_d = burst_q;
        if (enter_grant) begin
            burst_d = '0;
        end else if (state_q == ST_GRANT && burst_q != 8'hFF) begin
            burst_d = burst_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) burst_q <= '0;
        else         burst_q <= burst_d;
    end
`else
    assign burst_limit = 1'b0;
`endif

    // Zero-cycle memory mux; a write is suppressed if the CPU drops ack or reset is asserted.
    always_comb begin
        bus.dmem_addr  = bus.cpu_addr;
        bus.dmem_wdata = bus.cpu_wdata;
        bus.dmem_we    = bus.cpu_we;
        unique case (state_q)
            ST_GRANT: begin
                bus.dmem_addr  = ch_addr_arr[grant_id_q];
                bus.dmem_wdata = ch_wdata_arr[grant_id_q];
                bus.dmem_we    = bus.ch_we[grant_id_q] & bus.cpu_hold_ack & rst_ni;
            end
            ST_RELEASE: bus.dmem_we = 1'b0;
            default: ;
        endcase
    end

    assign bus.ch_hold_ack = (state_q == ST_GRANT) ? (N_CH'(1) << grant_id_q) : '0;
    assign bus.hold_req    = (state_q != ST_IDLE);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.grant_id    = grant_id_q;
endmodule

// File: tb/tb_dmem_hold_arbiter.sv
// Directed bench for dmem_hold_arbiter: passthrough, single grant, round-robin, preemption, ack loss, reset.
module tb_dmem_hold_arbiter;
    localparam int N_CH      = 4;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic clk;
    logic rst_ni;
    int   total = 0;
    int   bad   = 0;
    int   order [4] = '{0, 1, 3, 0};

    dmem_hold_arbiter_if #(.N_CH(N_CH), .AW(AW), .DW(DW)) bus ();

    dmem_hold_arbiter #(
        .N_CH(N_CH), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        clk              = 1'b0;
        rst_ni           = 1'b0;
        bus.ch_hold      = '0;
        bus.ch_we        = '0;
        bus.cpu_hold_ack = 1'b0;
        bus.cpu_we       = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_wdata    = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.ch_addr[i*AW +: AW]  = 32'h1000 + i;
            bus.ch_wdata[i*DW +: DW] = 32'hA000_0000 + i;
        end
        step();
        step();
        check("rst_hold_req", bus.hold_req, 0);
        check("rst_ack", bus.ch_hold_ack, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_busy", bus.busy, 0);

        // CPU passthrough; ungranted channel write enable is ignored
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 32'h40;
        bus.cpu_wdata = 32'h1234_5678;
        bus.ch_we     = 4'b0010;
        #1;
        check("pass_we", bus.dmem_we, 1);
        check("pass_addr", bus.dmem_addr, 32'h40);
        check("pass_wdata", bus.dmem_wdata, 32'h1234_5678);
        rst_ni = 1'b1;
        step();
        check("idle_busy", bus.busy, 0);
        check("idle_addr", bus.dmem_addr, 32'h40);

        // Single channel 2 request
        bus.cpu_we                = 1'b0;
        bus.ch_addr[2*AW +: AW]   = 32'h100;
        bus.ch_wdata[2*DW +: DW]  = 32'hDEAD_BEEF;
        bus.ch_we                 = 4'b0100;
        bus.ch_hold               = 4'b0100;
        step();
        check("req_hold_req", bus.hold_req, 1);
        check("req_ack", bus.ch_hold_ack, 0);
        check("req_we", bus.dmem_we, 0);
        check("req_addr", bus.dmem_addr, 32'h40);
        step();
        step();
        bus.cpu_hold_ack = 1'b1;
        step();
        check("single_ack", bus.ch_hold_ack, 4'b0100);
        check("single_gid", bus.grant_id, 2);
        check("single_addr", bus.dmem_addr, 32'h100);
        check("single_wdata", bus.dmem_wdata, 32'hDEAD_BEEF);
        check("single_we", bus.dmem_we, 1);
        bus.ch_hold = '0;
        bus.ch_we   = '0;
        bus.cpu_we  = 1'b1;
        step();
        check("single_rel_ack", bus.ch_hold_ack, 0);
        check("single_rel_hreq", bus.hold_req, 1);
        check("single_rel_we", bus.dmem_we, 0);
        step();
        check("single_idle_hreq", bus.hold_req, 0);
        check("single_idle_busy", bus.busy, 0);
        check("single_idle_gid", bus.grant_id, 2);
        check("single_idle_we", bus.dmem_we, 1);
        bus.cpu_we = 1'b0;

        // Round-robin 0,1,3,0 with one dead cycle between grants
        rst_ni = 1'b0;
        step();
        rst_ni      = 1'b1;
        bus.ch_we   = 4'b1111;
        bus.ch_hold = 4'b1011;
        step();
        check("rr_req_hreq", bus.hold_req, 1);
        check("rr_req_ack", bus.ch_hold_ack, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            check("rr_gid", bus.grant_id, order[k]);
            check("rr_ack", bus.ch_hold_ack, 4'b0001 << order[k]);
            check("rr_addr", bus.dmem_addr, 32'h1000 + order[k]);
            check("rr_we", bus.dmem_we, 1);
            step();
            check("rr_ack2", bus.ch_hold_ack, 4'b0001 << order[k]);
            bus.ch_hold[order[k]] = 1'b0;
            step();
            check("rr_dead_ack", bus.ch_hold_ack, 0);
            check("rr_dead_we", bus.dmem_we, 0);
            check("rr_dead_hreq", bus.hold_req, 1);
            bus.ch_hold[order[k]] = 1'b1;
            step();
        end

        // Burst behaviour with channels 0 and 1 held continuously
        rst_ni = 1'b0;
        step();
        rst_ni      = 1'b1;
        bus.ch_hold = 4'b0011;
        step();
        step();
`ifdef DMEM_ARB_PREEMPT_EN
        for (int c = 0; c < MAX_BURST; c++) begin
            check("pre_ch0", bus.ch_hold_ack, 4'b0001);
            step();
        end
        check("pre_rel0", bus.ch_hold_ack, 0);
        step();
        for (int c = 0; c < MAX_BURST; c++) begin
            check("pre_ch1", bus.ch_hold_ack, 4'b0010);
            step();
        end
        check("pre_rel1", bus.ch_hold_ack, 0);
        step();
        check("pre_back0", bus.ch_hold_ack, 4'b0001);
`else
        for (int c = 0; c < 10; c++) begin
            check("keep_ch0", bus.ch_hold_ack, 4'b0001);
            step();
        end
`endif

        // CPU ack withdrawn mid-grant
        bus.cpu_hold_ack = 1'b0;
        #1;
        check("ackloss_we_now", bus.dmem_we, 0);
        step();
        check("ackloss_ack", bus.ch_hold_ack, 0);
        check("ackloss_busy", bus.busy, 1);
        check("ackloss_hreq", bus.hold_req, 1);
        check("ackloss_we", bus.dmem_we, 0);
        check("ackloss_addr", bus.dmem_addr, 32'h40);
        bus.cpu_hold_ack = 1'b1;
        step();
        check("ackback_gid", bus.grant_id, 0);
        check("ackback_ack", bus.ch_hold_ack, 4'b0001);

        // Reset during grant with a write pending
        rst_ni = 1'b0;
        #1;
        check("rstg_we_now", bus.dmem_we, 0);
        step();
        check("rstg_ack", bus.ch_hold_ack, 0);
        check("rstg_hreq", bus.hold_req, 0);
        check("rstg_busy", bus.busy, 0);
        check("rstg_gid", bus.grant_id, 0);
        rst_ni = 1'b1;
        step();
        step();
        check("rstg_rr_ack", bus.ch_hold_ack, 4'b0001);
        check("rstg_rr_gid", bus.grant_id, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dmem_hold_arbiter.md
# dmem_hold_arbiter

Multi-channel successor to the single-DMA HOLD/HOLD_ACK data-memory mux. Arbitrates N_CH bus-master channels (DMA engines, coprocessors) against the CPU for the single data-memory port: raises one HOLD request to the CPU control unit, waits for the CPU's acknowledge, then grants the port to one channel at a time in round-robin order. Sits between `mips` and the data memory, replacing the three 2:1 `holdACK` muxes.

## Interface
- N_CH, 4, number of requesting channels (1..16)
- AW, 32, memory address width
- DW, 32, memory data width
- MAX_BURST, 16, grant cycles before forced rotation (used only with DMEM_ARB_PREEMPT_EN; 1..255)
- Derived: CW = max(1, clog2(N_CH))

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-low
- ch_hold  in  N_CH  per-channel bus request
- ch_hold_ack  out  N_CH  per-channel grant, one-hot or zero
- ch_addr  in  N_CH*AW  channel i address at [i*AW +: AW]
- ch_wdata  in  N_CH*DW  channel i write data at [i*DW +: DW]
- ch_we  in  N_CH  channel write enables
- cpu_addr / cpu_wdata  in  AW / DW  CPU data-memory address / write data
- cpu_we  in  1  CPU data-memory write enable
- hold_req  out  1  stall request to CPU control unit
- cpu_hold_ack  in  1  CPU confirms it is stalled and off the bus
- dmem_addr / dmem_wdata  out  AW / DW  to data memory
- dmem_we  out  1  to data memory
- grant_id  out  CW  index of current/last granted channel
- busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, GRANT, RELEASE (registered).
- IDLE: hold_req=0. Any ch_hold bit set -> REQ.
- REQ: hold_req=1. cpu_hold_ack=1 -> GRANT to winner; all ch_hold low before ack -> IDLE.
- Winner: first set ch_hold bit searching from index rr_ptr upward, wrapping mod N_CH. rr_ptr := grant_id+1 (mod N_CH) on every grant; reset value 0.
- GRANT: ch_hold_ack[grant_id]=1, hold_req=1; dmem_* = granted channel's addr/wdata/we. Leave on ch_hold[grant_id]=0, on cpu_hold_ack=0 (protocol error; go to REQ, no write issued that cycle), or on burst limit (see Configuration) -> RELEASE.
- RELEASE: one dead cycle; all ch_hold_ack=0; dmem_we forced 0. If any ch_hold set -> GRANT to next round-robin winner, hold_req stays 1 (CPU not released). Else -> IDLE, hold_req=0.
- IDLE/REQ: dmem_* = cpu_*. In REQ, dmem_we = cpu_we (CPU still owns bus until ack).
- Data-memory read data is broadcast by the top level; no read path here.
- Reset values: hold_req=0, ch_hold_ack=0, grant_id=0, busy=0, state IDLE, rr_ptr=0; dmem_* follow cpu_* combinationally.

## Timing
- ch_hold rise in cycle t (IDLE) -> hold_req=1 in t+1.
- cpu_hold_ack sampled 1 in cycle k (REQ) -> ch_hold_ack and dmem_* switched in k+1.
- dmem_addr/wdata/we are combinational from registered state/grant_id and the live inputs: zero-cycle path from granted channel to memory.
- ch_hold drop in cycle t -> ch_hold_ack=0 in t+1 (RELEASE), next grant t+2 at earliest.
- Minimum handoff between channels: 1 dead cycle. Minimum single-request latency: 2 cycles + CPU ack latency.
- Reset asserted mid-GRANT: next edge all outputs to reset values; an in-flight write is not issued on that cycle.
- ch_hold on a non-granted channel never affects dmem_*.

## Configuration
- DMEM_ARB_PREEMPT_EN defined: 8-bit burst counter cleared on entry to GRANT, increments each GRANT cycle; reaching MAX_BURST while any other ch_hold bit is set -> RELEASE. The preempted channel sees ch_hold_ack drop with ch_hold still high and must stall until re-granted. Counter saturates if no contender.
- Not defined: no counter; a channel keeps the bus until it drops ch_hold.

## Test plan
- Single channel: ch_hold[2]=1, cpu_hold_ack rises 3 cycles after hold_req -> ch_hold_ack=4'b0100 next cycle, dmem_addr=ch_addr[2], one write 0xDEADBEEF to 0x100 lands; drop hold -> RELEASE, IDLE, hold_req=0.
- Round-robin: ch_hold=4'b1011 held, each channel drops after 2 cycles then re-raises -> grant order 0,1,3,0; one dead cycle with dmem_we=0 between each; hold_req never drops.
- CPU passthrough: IDLE with cpu_we=1, cpu_addr=0x40 -> dmem_we=1, dmem_addr=0x40; ch_we=1 on ungranted channel -> no effect.
- Preemption (macro on, MAX_BURST=4): ch0 and ch1 held continuously -> ch0 granted exactly 4 cycles, RELEASE, ch1 4 cycles; macro off -> ch0 keeps bus indefinitely.
- CPU ack withdrawn mid-GRANT -> ch_hold_ack=0 next cycle, state REQ, dmem_we=0; ack returns -> same round-robin winner re-granted.
- rst=0 during GRANT with ch_we=1 -> next cycle ch_hold_ack=0, hold_req=0, busy=0, grant_id=0, rr_ptr=0.
